// File: rtl/digit_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : digit_timing_gen
// Description : Digit / minor-cycle timing chain. Counts digits within each
//               minor cycle and minor cycles within each major cycle, decodes
//               the timing strobes, and serialises the active order word onto
//               order_pulse, one bit per digit, LSB first.
// Revision    : 1.0 - initial release
// ============================================================================
module digit_timing_gen #(
    parameter int DIGITS          = 18,
    parameter int MINOR_PER_MAJOR = 4,
    parameter int ORDER_WIDTH     = 17
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               run,
    input  logic [ORDER_WIDTH-1:0]             order_in,
    input  logic                               order_load,
    output logic [$clog2(DIGITS)-1:0]          digit,
    output logic [$clog2(MINOR_PER_MAJOR)-1:0] minor,
    output logic                               running,
    output logic                               d0,
    output logic                               d1,
    output logic                               d17,
    output logic                               ev,
    output logic                               ev_d0,
    output logic                               ev_d1,
    output logic                               zero_d0,
    output logic                               order_pulse,
    output logic                               order_ack
);

    localparam int DW = $clog2(DIGITS);
    localparam int MW = $clog2(MINOR_PER_MAJOR);

    localparam logic [DW-1:0] c_DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [DW-1:0] c_DIGIT_ONE  = DW'(1);
    localparam logic [MW-1:0] c_MINOR_LAST = MW'(MINOR_PER_MAJOR - 1);
    localparam logic [MW-1:0] c_MINOR_ONE  = MW'(1);

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DW-1:0]          r_digit;
    logic [DW-1:0]          w_digit_nxt;
    logic [MW-1:0]          r_minor;
    logic [MW-1:0]          w_minor_nxt;

    logic [ORDER_WIDTH-1:0] r_pending;
    logic                   r_pending_valid;
    logic [ORDER_WIDTH-1:0] r_order_sr;
    logic                   r_order_ack;

    logic                   w_running;
    logic                   w_boundary;
    logic                   w_transfer;
    logic                   w_order_bit;

    assign w_running  = (r_state == ST_RUNNING);
    // Last digit of a running minor cycle: where stop and order transfer act.
    assign w_boundary = w_running && (r_digit == c_DIGIT_LAST);
    assign w_transfer = w_boundary && r_pending_valid;

    // State, digit and minor-cycle registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_STOPPED;
            r_digit <= '0;
            r_minor <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_minor <= w_minor_nxt;
        end
    end

    // Next-state logic: counters advance while running; stop only at a boundary.
    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_minor_nxt = r_minor;
        case (r_state)
            ST_STOPPED: begin
                w_digit_nxt = '0;
                w_minor_nxt = '0;
                if (run) begin
                    w_state_nxt = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (r_digit == c_DIGIT_LAST) begin
                    w_digit_nxt = '0;
                    if (!run) begin
                        w_state_nxt = ST_STOPPED;
                        w_minor_nxt = '0;
                    end else if (r_minor == c_MINOR_LAST) begin
                        w_minor_nxt = '0;
                    end else begin
                        w_minor_nxt = r_minor + c_MINOR_ONE;
                    end
                end else begin
                    w_digit_nxt = r_digit + c_DIGIT_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_STOPPED;
                w_digit_nxt = '0;
                w_minor_nxt = '0;
            end
        endcase
    end

    // Pending/active order registers; a load on the transfer cycle stays pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_order_sr      <= '0;
            r_order_ack     <= 1'b0;
        end else begin
            if (order_load) begin
                r_pending       <= order_in;
                r_pending_valid <= 1'b1;
            end else if (w_transfer) begin
                r_pending_valid <= 1'b0;
            end
            if (w_transfer) begin
                r_order_sr <= r_pending;
            end
            r_order_ack <= w_transfer;
        end
    end

    // Select the order bit for the current digit; digits past the word give 0.
    always_comb begin
        w_order_bit = 1'b0;
        for (int i = 0; i < ORDER_WIDTH; i++) begin
            if (r_digit == DW'(i)) begin
                w_order_bit = r_order_sr[i];
            end
        end
    end

    assign digit       = r_digit;
    assign minor       = r_minor;
    assign running     = w_running;
    assign d0          = w_running && (r_digit == '0);
    assign d1          = w_running && (r_digit == c_DIGIT_ONE);
    assign d17         = w_boundary;
    assign ev          = w_running && !r_minor[0];
    assign ev_d0       = ev && d0;
    assign ev_d1       = ev && d1;
    assign zero_d0     = d0 && (r_minor == '0);
    assign order_pulse = w_running && w_order_bit;
    assign order_ack   = r_order_ack;

endmodule
`default_nettype wire

// File: tb/tb_digit_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_digit_timing_gen
// Description : Directed self-checking bench for digit_timing_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_digit_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [16:0] order_in;
    logic        order_load;
    logic [4:0]  digit;
    logic [1:0]  minor;
    logic        running, d0, d1, d17, ev, ev_d0, ev_d1, zero_d0;
    logic        order_pulse, order_ack;

    int checks   = 0;
    int failures = 0;

    digit_timing_gen #(
        .DIGITS          (18),
        .MINOR_PER_MAJOR (4),
        .ORDER_WIDTH     (17)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .order_in    (order_in),
        .order_load  (order_load),
        .digit       (digit),
        .minor       (minor),
        .running     (running),
        .d0          (d0),
        .d1          (d1),
        .d17         (d17),
        .ev          (ev),
        .ev_d0       (ev_d0),
        .ev_d1       (ev_d1),
        .zero_d0     (zero_d0),
        .order_pulse (order_pulse),
        .order_ack   (order_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until (digit, minor) matches, bounded.
    task automatic wait_pos(input int d, input int m);
        int n = 0;
        while (!(digit == 5'(d) && minor == 2'(m)) && n < 200) begin
            tick();
            n++;
        end
        check("wait_pos", {31'd0, (digit == 5'(d) && minor == 2'(m))}, 32'd1);
    endtask

    // Collect order_pulse over one minor cycle (index = cycles since start)
    // and count any order_ack seen after the first cycle.
    task automatic collect(output logic [17:0] pat, output int extra_acks);
        pat = '0;
        extra_acks = 0;
        for (int k = 0; k < 18; k++) begin
            if (order_pulse) pat[k] = 1'b1;
            if (k > 0 && order_ack) extra_acks++;
            tick();
        end
    endtask

    initial begin
        int          errs;
        int          n_d17, n_z, n_ev, p, n;
        logic [7:0]  mseq;
        logic [17:0] pat;
        int          acks, pulses;

        rst = 1'b1; run = 1'b0; order_in = '0; order_load = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_running", {31'd0, running}, 32'd0);
        check("rst_digit",   {27'd0, digit},   32'd0);
        check("rst_minor",   {30'd0, minor},   32'd0);
        check("rst_strobes", {25'd0, d0, d1, d17, ev, ev_d0, ev_d1, zero_d0}, 32'd0);
        check("rst_order",   {30'd0, order_pulse, order_ack}, 32'd0);

        // 1: start
        run = 1'b1;
        tick();
        check("start_running", {31'd0, running}, 32'd1);
        check("start_digit",   {27'd0, digit},   32'd0);
        check("start_zero_d0", {31'd0, zero_d0}, 32'd1);
        check("start_ev_d0",   {31'd0, ev_d0},   32'd1);
        tick();
        check("d1_digit", {27'd0, digit}, 32'd1);
        check("d1_ev_d1", {31'd0, ev_d1}, 32'd1);
        check("d1_d0",    {31'd0, d0},    32'd0);

        // 2: free run over one major cycle from position 1
        errs = 0; n_d17 = 0; n_z = 0; n_ev = 0; mseq = '0; p = 1;
        for (int k = 0; k < 72; k++) begin
            tick();
            p = (p + 1) % 72;
            if (digit != 5'(p % 18) || minor != 2'(p / 18)) errs++;
            if (ev !== ((p / 18) % 2 == 0)) errs++;
            if (d17 !== (p % 18 == 17)) errs++;
            if (d1 !== (p % 18 == 1)) errs++;
            if (zero_d0 !== (p == 0)) errs++;
            if (d17) n_d17++;
            if (zero_d0) n_z++;
            if (ev) n_ev++;
            if (d0) mseq = {mseq[5:0], minor};
        end
        check("free_errs",  errs,  0);
        check("free_d17",   n_d17, 4);
        check("free_zero",  n_z,   1);
        check("free_ev",    n_ev,  36);
        check("free_mseq",  {24'd0, mseq}, 32'h6C);

        // 3: stop request mid-cycle takes effect at the boundary
        wait_pos(5, 1);
        run = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        check("stop_late_running", {31'd0, running}, 32'd1);
        check("stop_late_digit",   {27'd0, digit},   32'd17);
        check("stop_late_d17",     {31'd0, d17},     32'd1);
        tick();
        check("stopped_running", {31'd0, running}, 32'd0);
        check("stopped_pos",     {25'd0, digit, minor}, 32'd0);
        check("stopped_strobes", {25'd0, d0, d1, d17, ev, ev_d0, ev_d1, zero_d0}, 32'd0);
        tick();
        check("stopped_hold", {24'd0, running, digit, minor}, 32'd0);
        run = 1'b1;
        tick();
        check("restart_zero_d0", {31'd0, zero_d0}, 32'd1);

        // 4: single load, transfer at boundary, persistent pattern
        wait_pos(8, 0);
        order_in = 17'h00011; order_load = 1'b1;
        tick();
        order_load = 1'b0;
        check("load_no_ack", {31'd0, order_ack}, 32'd0);
        pulses = 0; n = 0;
        while (digit != 5'd17 && n < 40) begin
            if (order_pulse) pulses++;
            tick();
            n++;
        end
        check("pre_xfer_pulses", pulses, 0);
        check("pre_xfer_ack",    {31'd0, order_ack}, 32'd0);
        tick();
        check("xfer_ack",   {31'd0, order_ack}, 32'd1);
        check("xfer_d0",    {31'd0, d0},        32'd1);
        collect(pat, acks);
        check("pat_minor1", {14'd0, pat}, 32'h00011);
        check("acks_minor1", acks, 0);
        collect(pat, acks);
        check("pat_minor2", {14'd0, pat}, 32'h00011);
        check("acks_minor2", {31'd0, order_ack}, 32'd0);

        // 5: A, B overwrite, C loaded on the boundary cycle
        wait_pos(3, 3);
        order_in = 17'h0AAAA; order_load = 1'b1;
        tick();
        order_load = 1'b0;
        wait_pos(6, 3);
        order_in = 17'h00105; order_load = 1'b1;
        tick();
        order_load = 1'b0;
        wait_pos(17, 3);
        order_in = 17'h10003; order_load = 1'b1;
        tick();
        order_load = 1'b0;
        check("ack_b", {31'd0, order_ack}, 32'd1);
        collect(pat, acks);
        check("pat_b", {14'd0, pat}, 32'h00105);
        check("acks_b", acks, 0);
        check("ack_c", {31'd0, order_ack}, 32'd1);
        collect(pat, acks);
        check("pat_c", {14'd0, pat}, 32'h10003);

        // 6: reset mid-cycle with a pending order and a coincident load
        wait_pos(3, 2);
        order_in = 17'h1FFFF; order_load = 1'b1;
        tick();
        order_load = 1'b0;
        wait_pos(9, 2);
        rst = 1'b1; order_load = 1'b1;
        tick();
        rst = 1'b0; order_load = 1'b0;
        check("rst2_state", {24'd0, running, digit, minor}, 32'd0);
        check("rst2_out",   {23'd0, d0, d1, d17, ev, ev_d0, ev_d1, zero_d0, order_pulse, order_ack}, 32'd0);
        tick();
        check("rst2_restart", {31'd0, running}, 32'd1);
        pulses = 0; acks = 0;
        for (int k = 0; k < 72; k++) begin
            if (order_pulse) pulses++;
            if (order_ack) acks++;
            tick();
        end
        check("rst2_pulses", pulses, 0);
        check("rst2_acks",   acks,   0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/digit_timing_gen.md
Name: digit_timing_gen

Overview:
Upstream timing source for the shift-control unit and the other CCUs. It counts pulse intervals (digits) within each minor cycle and minor cycles within each major cycle. From these counts it decodes the digit and minor-cycle strobes (d0, d1, d17, ev, ev_d0, ev_d1, zero_d0) that the control units consume. It also holds the current order and serialises it onto the order pulse train, one bit per digit, so downstream coincidence logic (shift termination) can compare the order position against digit pulses.

Parameters:
DIGITS, 18, pulse intervals per minor cycle (17 data digits + 1 gap)
MINOR_PER_MAJOR, 4, minor cycles per major cycle; must be even and >=2
ORDER_WIDTH, 17, bits in the order word serialised onto order_pulse; must be <= DIGITS

Ports:
clk  input  1  system clock; one pulse interval per cycle
rst  input  1  synchronous, active-high reset
run  input  1  level; request to run (1) or stop (0) the timing chain
order_in  input  ORDER_WIDTH  order word to be loaded
order_load  input  1  one-cycle strobe; capture order_in into the pending register
digit  output  clog2(DIGITS)  current digit count
minor  output  clog2(MINOR_PER_MAJOR)  current minor-cycle count
running  output  1  timing chain active
d0  output  1  digit==0 & running
d1  output  1  digit==1 & running
d17  output  1  digit==DIGITS-1 & running
ev  output  1  minor[0]==0 (even minor cycle) & running
ev_d0  output  1  ev & d0
ev_d1  output  1  ev & d1
zero_d0  output  1  d0 & minor==0
order_pulse  output  1  running & order_sr[digit] when digit<ORDER_WIDTH, else 0
order_ack  output  1  one-cycle pulse: pending order transferred to active register

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - digit=0, minor=0, running=0.
  - Pending register empty; active order register order_sr=0; order_ack=0.
  - All decoded strobes are 0 because running=0.
  - Reset overrides everything, including mid-minor-cycle operation and a simultaneous order_load.
- Counters and registers are registered. d0, d1, d17, ev, ev_d0, ev_d1, zero_d0 and order_pulse are combinational decodes of the registered state. order_ack is registered.
- State machine, two states:
  - STOPPED:
    - digit and minor held at 0.
    - run=1 moves to RUNNING next cycle, with digit=0 and minor=0 in the first RUNNING cycle. zero_d0 and ev_d0 are therefore high on that cycle.
  - RUNNING:
    - digit increments each cycle and wraps DIGITS-1 -> 0.
    - On wrap, minor increments and wraps MINOR_PER_MAJOR-1 -> 0.
    - Stop happens only at a minor-cycle boundary: if run=0 is sampled on a cycle with digit==DIGITS-1, the next state is STOPPED with digit=0 and minor=0.
    - run=0 at any other digit is ignored until the boundary. The run level is re-sampled at each boundary.
- Order handling:
  - order_load=1 writes order_in into the pending register and sets pending_valid. A later load before transfer overwrites it (latest wins).
  - Transfer occurs on a RUNNING cycle with digit==DIGITS-1 and pending_valid=1:
    - order_sr <= pending;
    - pending_valid <= 0;
    - order_ack=1 on the following cycle (coincident with d0 of the new minor cycle).
  - If order_load and transfer happen on the same cycle: the old pending word transfers, the new word becomes pending with pending_valid=1.
  - No pending word at a boundary: order_sr is retained unchanged; the order persists across minor cycles until replaced.
  - In STOPPED, no transfer occurs, but loads are still captured into pending.
- order_pulse: bit i of order_sr appears at digit i (LSB first). Digits >= ORDER_WIDTH give 0.

Test Plan:
1. Reset then run=1: cycle after run -> running=1, digit=0, zero_d0=1, ev_d0=1. Next cycle: digit=1, ev_d1=1, d0=0.
2. Free run for 4*18=72 cycles with defaults: d17 fires every 18 cycles. ev is high in minors 0 and 2 only. zero_d0 fires once per 72 cycles. minor sequence is 0,1,2,3,0.
3. Deassert run at digit 5 of minor 1: counting continues through digit 17. Next cycle: running=0, digit=0, all strobes 0. Reassert run -> restart with zero_d0.
4. order_in=17'h00011, load mid-cycle: at the next d17 the transfer occurs and order_ack=1 at the following d0. order_pulse is high at digits 0 and 4 only, repeated every minor cycle thereafter with no further loads.
5. Load A, then load B before the boundary, then load C on the boundary cycle: B becomes active with order_ack. C stays pending and transfers at the next boundary with a second order_ack.
6. Assert rst at digit 9 of minor 2 with a pending order: next cycle all outputs 0, running=0. The following order_load-free run shows order_pulse=0 at every digit.
